arbiter_grant_lock: RTL and testbench

Sequential grant-locking stage wrapped around the fixed-priority combinational arbiter. It drives the arbiter's request vector and consumes its one-hot grant. It registers the grant and holds it for the winning requester until that requester drops its request or a hold limit expires. After a forced release, the timed-out requester is masked for one arbitration so lower priorities cannot starve.

---
 rtl/arbiter_pkg.sv | 15 +
 rtl/arbiter_fixed_prio.sv | 12 +
 rtl/arbiter_grant_lock.sv | 130 +++++++++++++
 tb/tb_arbiter_grant_lock.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the grant-locking arbiter stage.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } arb_lock_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_fixed_prio.sv
// Combinational fixed-priority arbiter: the lowest-index request wins.
module arbiter_fixed_prio #(
    parameter int NUM = 4
) (
    input  logic [NUM-1:0] req_i,
    output logic [NUM-1:0] gnt_o
);

    // Isolate the lowest set bit.
    assign gnt_o = req_i & ~(req_i - NUM'(1));

endmodule

// File: rtl/arbiter_grant_lock.sv
// Locks the arbiter's grant onto one owner until it drops its request or the
// hold limit expires; a timed-out owner is masked for the next arbitration.
module arbiter_grant_lock
    import arbiter_pkg::*;
#(
    parameter  int NUM      = 4,
    parameter  int MAX_HOLD = 8,
    localparam int OW       = owner_width(NUM),
    localparam int HW       = owner_width(MAX_HOLD)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NUM-1:0] req_i,
    output logic [NUM-1:0] req_o,
    input  logic [NUM-1:0] arb_gnt_i,
    output logic [NUM-1:0] gnt_o,
    output logic [OW-1:0]  owner_o,
    output logic           busy_o,
    output logic           timeout_o,
    output logic           error_o
);

    arb_lock_state_e state_reg, state_next;
    logic [NUM-1:0]  gnt_reg, gnt_next;
    logic [NUM-1:0]  mask_reg, mask_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic            busy_reg, busy_next;
    logic            timeout_reg, timeout_next;
    logic            error_reg, error_next;

    logic [NUM-1:0]  req_masked;
    logic            arb_ok;
    logic [OW-1:0]   arb_idx;

    // The mask only steers arbitration away from a timed-out owner; it never
    // leaves a sole requester without a request.
    always_comb begin
        req_masked = req_i & ~mask_reg;
        req_o      = (req_masked != '0) ? req_masked : req_i;
    end

    always_comb begin
        arb_ok = (arb_gnt_i != '0)
              && ((arb_gnt_i & (arb_gnt_i - NUM'(1))) == '0)
              && ((arb_gnt_i & req_o) == arb_gnt_i);
        arb_idx = '0;
        for (int i = 0; i < NUM; i++) begin
            if (arb_gnt_i[i]) begin
                arb_idx = OW'(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        mask_next     = mask_reg;
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        error_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_gnt_i != '0) begin
                    if (arb_ok) begin
                        gnt_next      = arb_gnt_i;
                        owner_next    = arb_idx;
                        hold_cnt_next = '0;
                        mask_next     = '0;
                        state_next    = LOCKED;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            LOCKED: begin
                // A voluntary drop wins over an expiring hold in the same cycle.
                if (!req_i[owner_reg]) begin
                    gnt_next   = '0;
                    state_next = RELEASE;
                end else if (hold_cnt_reg == HW'(MAX_HOLD - 1)) begin
                    gnt_next     = '0;
                    timeout_next = 1'b1;
                    mask_next    = gnt_reg;
                    state_next   = RELEASE;
                end else if (hold_cnt_reg != '1) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
        busy_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            mask_reg     <= '0;
            owner_reg    <= '0;
            hold_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            mask_reg     <= mask_next;
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
            busy_reg     <= busy_next;
            timeout_reg  <= timeout_next;
            error_reg    <= error_next;
        end
    end

    assign gnt_o     = gnt_reg;
    assign owner_o   = owner_reg;
    assign busy_o    = busy_reg;
    assign timeout_o = timeout_reg;
    assign error_o   = error_reg;

endmodule

// File: tb/tb_arbiter_grant_lock.sv
// Bench: grant-lock stage wired back-to-back with the fixed-priority arbiter.
module tb_arbiter_grant_lock;

    localparam int NUM      = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req_i = '0;
    logic [3:0] req_o;
    logic [3:0] arb_gnt_raw;
    logic [3:0] arb_gnt;
    logic [3:0] gnt_o;
    logic [1:0] owner_o;
    logic       busy_o, timeout_o, error_o;
    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index (-1 none), cycles already granted,
    // turnaround cycles left, masked index (-1 none), last timeout pulse.
    int m_owner = -1;
    int m_held = 0;
    int m_dead = 0;
    int m_masked = -1;
    bit m_timeout = 1'b0;

    always #5 clk = ~clk;

    assign arb_gnt = force_en ? force_val : arb_gnt_raw;

    arbiter_fixed_prio #(.NUM(NUM)) u_arb (
        .req_i (req_o),
        .gnt_o (arb_gnt_raw)
    );

    arbiter_grant_lock #(.NUM(NUM), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_i),
        .req_o     (req_o),
        .arb_gnt_i (arb_gnt),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .error_o   (error_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_req_o(input logic [3:0] r);
        logic [3:0] m;
        m = r;
        if (m_masked >= 0) m[m_masked] = 1'b0;
        return (m != 4'b0000) ? m : r;
    endfunction

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] eff;
        eff = model_req_o(r);
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_dead  = 1;
            end else if (m_held == MAX_HOLD) begin
                m_masked  = m_owner;
                m_owner   = -1;
                m_dead    = 1;
                m_timeout = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (eff != 4'b0000) begin
            for (int i = NUM - 1; i >= 0; i--) begin
                if (eff[i]) m_owner = i;
            end
            m_held   = 1;
            m_masked = -1;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_dead = 0; m_masked = -1; m_timeout = 1'b0;
    endtask

    // One clock of stimulus compared against the model; starts just after an edge.
    task automatic cycle_model(input logic [3:0] r);
        req_i = r;
        #1;
        chk("req_o", req_o, model_req_o(r));
        model_edge(r);
        @(posedge clk);
        #1;
        chk("gnt_o", gnt_o, model_gnt());
        chk("busy_o", busy_o, m_owner >= 0);
        chk("timeout_o", timeout_o, m_timeout);
        chk("error_o", error_o, 1'b0);
        if (m_owner >= 0) chk("owner_o", owner_o, m_owner);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_req_o;
        logic [3:0] exp_gnt;
        logic       exp_busy;
        logic       exp_timeout;
    } vec_t;

    vec_t vol_tab[8];
    vec_t to_tab[14];

    task automatic run_vec(input string tag, input vec_t v);
        req_i = v.req;
        #1;
        chk({tag, " req_o"}, req_o, v.exp_req_o);
        @(posedge clk);
        #1;
        chk({tag, " gnt_o"}, gnt_o, v.exp_gnt);
        chk({tag, " busy_o"}, busy_o, v.exp_busy);
        chk({tag, " timeout_o"}, timeout_o, v.exp_timeout);
        $display("%s req=%b gnt=%b busy=%b timeout=%b", tag, v.req, gnt_o, busy_o, timeout_o);
    endtask

    initial begin
        int rise_prev;
        logic [3:0] gprev;
        logic [3:0] r;

        vol_tab = '{
            '{4'b0110, 4'b0110, 4'b0010, 1'b1, 1'b0},
            '{4'b0110, 4'b0110, 4'b0010, 1'b1, 1'b0},
            '{4'b0110, 4'b0110, 4'b0010, 1'b1, 1'b0},
            '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0},
            '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0},
            '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0},
            '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0}
        };
        for (int i = 0; i < 8; i++) to_tab[i] = '{4'b0011, 4'b0011, 4'b0001, 1'b1, 1'b0};
        to_tab[8]  = '{4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b1};
        to_tab[9]  = '{4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0};
        to_tab[10] = '{4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b0};
        to_tab[11] = '{4'b0011, 4'b0011, 4'b0010, 1'b1, 1'b0};
        to_tab[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        to_tab[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

        // Reset with every requester active.
        req_i = 4'b1111;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst gnt_o", gnt_o, 4'b0000);
        chk("rst busy_o", busy_o, 1'b0);
        chk("rst timeout_o", timeout_o, 1'b0);
        chk("rst error_o", error_o, 1'b0);
        chk("rst owner_o", owner_o, 2'd0);
        chk("rst req_o", req_o, 4'b1111);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first grant gnt_o", gnt_o, 4'b0001);
        chk("first grant busy_o", busy_o, 1'b1);
        $display("reset release gnt=%b busy=%b", gnt_o, busy_o);
        model_reset();
        m_owner = 0; m_held = 1;
        cycle_model(4'b0000);
        cycle_model(4'b0000);

        for (int i = 0; i < 8; i++) run_vec("voluntary", vol_tab[i]);
        for (int i = 0; i < 14; i++) run_vec("timeout", to_tab[i]);

        // Sole requester: re-granted every MAX_HOLD+2 cycles.
        model_reset();
        rise_prev = -1;
        gprev = '0;
        for (int c = 0; c < 32; c++) begin
            cycle_model(4'b1000);
            if (gnt_o[3] && !gprev[3]) begin
                if (rise_prev >= 0) chk("sole regrant period", c - rise_prev, MAX_HOLD + 2);
                rise_prev = c;
            end
            gprev = gnt_o;
        end
        $display("sole requester last rise at cycle %0d", rise_prev);
        cycle_model(4'b0000);
        cycle_model(4'b0000);

        // Arbiter grant that is not one-hot.
        force_en = 1'b1; force_val = 4'b0101; req_i = 4'b0101;
        @(posedge clk); #1;
        chk("bad onehot error_o", error_o, 1'b1);
        chk("bad onehot gnt_o", gnt_o, 4'b0000);
        chk("bad onehot busy_o", busy_o, 1'b0);
        $display("bad grant 0101 error=%b gnt=%b", error_o, gnt_o);
        force_en = 1'b0; req_i = 4'b0000;
        @(posedge clk); #1;
        chk("error pulse width", error_o, 1'b0);
        // Arbiter grant outside the request set.
        force_en = 1'b1; force_val = 4'b0100; req_i = 4'b0001;
        @(posedge clk); #1;
        chk("bad subset error_o", error_o, 1'b1);
        chk("bad subset gnt_o", gnt_o, 4'b0000);
        $display("bad grant 0100 vs req 0001 error=%b gnt=%b", error_o, gnt_o);
        force_en = 1'b0; req_i = 4'b0010;
        @(posedge clk); #1;
        chk("still idle after error", gnt_o, 4'b0010);
        chk("error cleared", error_o, 1'b0);
        model_reset();
        m_owner = 1; m_held = 1;
        cycle_model(4'b0000);
        cycle_model(4'b0000);

        // Asynchronous reset while locked.
        req_i = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset gnt_o", gnt_o, 4'b0001);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst gnt_o", gnt_o, 4'b0000);
        chk("async rst busy_o", busy_o, 1'b0);
        chk("async rst timeout_o", timeout_o, 1'b0);
        $display("mid-lock reset gnt=%b busy=%b timeout=%b", gnt_o, busy_o, timeout_o);
        @(posedge clk);
        #3 rst_n = 1'b1;
        req_i = 4'b0000;
        @(posedge clk); #1;
        chk("post-reset idle gnt_o", gnt_o, 4'b0000);
        chk("post-reset timeout_o", timeout_o, 1'b0);

        // Randomized traffic, mostly-stable requests to reach the hold limit.
        model_reset();
        r = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            cycle_model(r);
        end
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
